// File: rtl/acia_uart.sv
// acia_uart: 6850-style ACIA, 8N1 serial port on the 6502 SoC bus.
// Two registers (rs=0 status/control, rs=1 data). Bit timing runs off the
// pclk enable; one bit lasts BAUD_DIV = clk_freq/BAUD pclk ticks.
// Optional feature: define ACIA_OVERRUN_EN to add the OVRN flag (status[5]).
//
// Bus access: a transfer happens on every clk edge where cs_n=0. we_n=0 is a
// write of din to the register chosen by rs; we_n=1 is a read. Reads return
// dout on the following cycle and dout holds while cs_n=1. There is no wait
// state; the bus never stalls.
module acia_uart #(
   parameter int clk_freq = 4000000,
   parameter int BAUD     = 115200
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       pclk,
   input  logic       cs_n,
   input  logic       we_n,
   input  logic       rs,
   input  logic       rx,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       tx,
   output logic       irq_n
);

   localparam int BAUD_DIV = clk_freq / BAUD;
   localparam int HALF_DIV = BAUD_DIV / 2;
   localparam int CW       = $clog2(BAUD_DIV + 1);
   localparam logic [CW-1:0] DIV_LAST  = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   // bus decode
   logic wr_ctrl, wr_data, rd_data, mreset;
   assign wr_ctrl = ~cs_n & ~we_n & ~rs;
   assign wr_data = ~cs_n & ~we_n &  rs;
   assign rd_data = ~cs_n &  we_n &  rs;
   assign mreset  = wr_ctrl & (din[1:0] == 2'b11);

   // control / status registers
   logic       rie_q, tie_q, tdre_q, rdrf_q, irq_n_q, ovrn_bit;
   logic [7:0] rx_data_q, dout_q, status;

   // transmitter state
   tx_state_t     tx_state_q, tx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]    tx_bit_q, tx_bit_d;
   logic [7:0]    tx_shift_q, tx_shift_d;
   logic          tx_q, tx_d, tx_done, tx_tick_end;

   // receiver state
   rx_state_t     rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_shift_q, rx_shift_d;
   logic          rx_sync1_q, rx_sync2_q, rx_prev_q, rx_done, rx_tick_end;

   assign tx_tick_end = pclk && (tx_cnt_q == DIV_LAST);
   assign rx_tick_end = pclk && (rx_cnt_q == DIV_LAST);

   // TX next-state: a write while TDRE=1 launches a frame; each bit is BAUD_DIV ticks
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_done    = 1'b0;
      if (pclk) tx_cnt_d = tx_cnt_q + 1'b1;
      case (tx_state_q)
         TX_IDLE: begin
            tx_cnt_d = '0;
            if (wr_data && tdre_q) begin
               tx_shift_d = din;
               tx_state_d = TX_START;
            end
         end
         TX_START: begin
            if (tx_tick_end) begin
               tx_cnt_d   = '0;
               tx_bit_d   = 3'd0;
               tx_state_d = TX_DATA;
            end
         end
         TX_DATA: begin
            if (tx_tick_end) begin
               tx_cnt_d = '0;
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = TX_STOP;
               end else begin
                  tx_bit_d   = tx_bit_q + 3'd1;
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
               end
            end
         end
         TX_STOP: begin
            if (tx_tick_end) begin
               tx_cnt_d   = '0;
               tx_state_d = TX_IDLE;
               tx_done    = 1'b1;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
      if (mreset) begin
         tx_state_d = TX_IDLE;
         tx_cnt_d   = '0;
         tx_bit_d   = 3'd0;
         tx_done    = 1'b0;
      end
      // line level follows the state being entered so tx is a clean flop output
      case (tx_state_d)
         TX_START: tx_d = 1'b0;
         TX_DATA:  tx_d = tx_shift_d[0];
         default:  tx_d = 1'b1;
      endcase
   end

   // TX state register; async reset drives the line idle immediately
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= 3'd0;
         tx_shift_q <= 8'h00;
         tx_q       <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_q       <= tx_d;
      end
   end

   // RX synchronizer and edge-detect history, idle high out of reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_sync1_q <= 1'b1;
         rx_sync2_q <= 1'b1;
         rx_prev_q  <= 1'b1;
      end else begin
         rx_sync1_q <= rx;
         rx_sync2_q <= rx_sync1_q;
         rx_prev_q  <= rx_sync2_q;
      end
   end

   // RX next-state: find start edge, re-check at half bit, then sample mid-bit
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_done    = 1'b0;
      if (pclk) rx_cnt_d = rx_cnt_q + 1'b1;
      case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            if (rx_prev_q && !rx_sync2_q) rx_state_d = RX_START;
         end
         RX_START: begin
            if (pclk && (rx_cnt_q == HALF_LAST)) begin
               rx_cnt_d = '0;
               rx_bit_d = 3'd0;
               // line back high at mid start bit: glitch, not a frame
               rx_state_d = rx_sync2_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_tick_end) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
               else                  rx_bit_d   = rx_bit_q + 3'd1;
            end
         end
         RX_STOP: begin
            if (rx_tick_end) begin
               rx_cnt_d   = '0;
               rx_state_d = RX_IDLE;
               // a low stop bit is a framing error and the byte is dropped
               rx_done    = rx_sync2_q;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
      if (mreset) begin
         rx_state_d = RX_IDLE;
         rx_cnt_d   = '0;
         rx_bit_d   = 3'd0;
         rx_done    = 1'b0;
      end
   end

   // RX state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= 3'd0;
         rx_shift_q <= 8'h00;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
      end
   end

   // flags, control, received byte, interrupt and read-data registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rie_q     <= 1'b0;
         tie_q     <= 1'b0;
         tdre_q    <= 1'b1;
         rdrf_q    <= 1'b0;
         rx_data_q <= 8'h00;
         irq_n_q   <= 1'b1;
         dout_q    <= 8'h00;
      end else begin
         if (wr_ctrl) begin
            rie_q <= din[7];
            tie_q <= (din[6:5] == 2'b01);
         end
         if (mreset)                    tdre_q <= 1'b1;
         else if (tx_done)              tdre_q <= 1'b1;
         else if (wr_data && tdre_q)    tdre_q <= 1'b0;
         // a byte landing on the same edge as a data read keeps RDRF set
         if (mreset)       rdrf_q <= 1'b0;
         else if (rx_done) rdrf_q <= 1'b1;
         else if (rd_data) rdrf_q <= 1'b0;
         if (rx_done) rx_data_q <= rx_shift_q;
         irq_n_q <= ~((rie_q & rdrf_q) | (tie_q & tdre_q));
         if (!cs_n) dout_q <= rs ? rx_data_q : status;
      end
   end

`ifdef ACIA_OVERRUN_EN
   logic ovrn_q;
   // overrun: a byte arrived while the previous one was still unread
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                ovrn_q <= 1'b0;
      else if (mreset)             ovrn_q <= 1'b0;
      else if (rx_done && rdrf_q)  ovrn_q <= 1'b1;
      else if (rd_data)            ovrn_q <= 1'b0;
   end
   assign ovrn_bit = ovrn_q;
`else
   assign ovrn_bit = 1'b0;
`endif

   assign status = {~irq_n_q, 1'b0, ovrn_bit, 3'b000, tdre_q, rdrf_q};
   assign dout   = dout_q;
   assign tx     = tx_q;
   assign irq_n  = irq_n_q;

endmodule

// File: tb/tb_acia_uart.sv
// tb_acia_uart: directed bench for acia_uart at default parameters
// (BAUD_DIV = 34). pclk pulses every second clk, so one bit is 68 clks.
module tb_acia_uart;

   localparam int BIT_CLKS = 68;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       pclk = 1'b0;
   logic       cs_n = 1'b1;
   logic       we_n = 1'b1;
   logic       rs = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] din = 8'h00;
   logic [7:0] dout;
   logic       tx;
   logic       irq_n;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] rd;
   logic [7:0] exp_ovr_status;
   int         n;

   acia_uart dut (
      .clk     (clk),
      .reset_n (reset_n),
      .pclk    (pclk),
      .cs_n    (cs_n),
      .we_n    (we_n),
      .rs      (rs),
      .rx      (rx),
      .din     (din),
      .dout    (dout),
      .tx      (tx),
      .irq_n   (irq_n)
   );

   // clock and reset block: 100 MHz clk, pclk high every other cycle
   always #5 clk = ~clk;
   always @(negedge clk) pclk = ~pclk;

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wait_clks(input int cnt);
      repeat (cnt) @(negedge clk);
   endtask

   task automatic bus_write(input logic a_rs, input logic [7:0] d);
      @(negedge clk);
      cs_n = 1'b0; we_n = 1'b0; rs = a_rs; din = d;
      @(negedge clk);
      cs_n = 1'b1; we_n = 1'b1;
   endtask

   task automatic bus_read(input logic a_rs, output logic [7:0] d);
      @(negedge clk);
      cs_n = 1'b0; we_n = 1'b1; rs = a_rs;
      @(negedge clk);
      cs_n = 1'b1;
      d = dout;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      @(negedge clk);
      rx = 1'b0;
      wait_clks(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_clks(BIT_CLKS);
      end
      rx = stop_bit;
      wait_clks(BIT_CLKS);
      rx = 1'b1;
      wait_clks(8);
   endtask

   initial begin
      // reset values
      wait_clks(3);
      check_eq("reset_tx", 8'(tx), 8'h01);
      check_eq("reset_irq_n", 8'(irq_n), 8'h01);
      check_eq("reset_dout", dout, 8'h00);
      reset_n = 1'b1;
      wait_clks(2);
      bus_read(1'b0, rd);
      check_eq("status_after_reset", rd, 8'h02);

      // transmit 0x55: start 0, data LSB first, stop 1
      exp_q = {8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01};
      bus_write(1'b1, 8'h55);
      n = 0;
      while (tx == 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      // 34 ticks of a pclk that fires every 2nd clk: 67 or 68 clks by phase
      check_eq("tx_start_len", 8'(n inside {67, 68}), 8'h01);
      bus_read(1'b0, rd);
      check_eq("status_during_tx", rd, 8'h00);
      bus_write(1'b1, 8'hFF);   // TDRE=0: must not disturb the frame
      wait_clks(30);
      for (int b = 0; b < 9; b++) begin
         check_eq($sformatf("tx_bit%0d", b), 8'(tx), exp_q.pop_front());
         wait_clks(BIT_CLKS);
      end
      check_eq("tx_queue_empty", 8'(exp_q.size()), 8'h00);
      bus_read(1'b0, rd);
      check_eq("status_after_tx", rd, 8'h02);

      // receive 0xA5; TDRE stays 1 with the transmitter idle
      send_frame(8'hA5, 1'b1);
      bus_read(1'b0, rd);
      check_eq("status_rx_a5", rd, 8'h03);
      bus_read(1'b1, rd);
      check_eq("data_rx_a5", rd, 8'hA5);
      wait_clks(3);
      check_eq("dout_hold", dout, 8'hA5);
      bus_read(1'b0, rd);
      check_eq("status_after_read", rd, 8'h02);

      // receive interrupt
      bus_write(1'b0, 8'h80);
      wait_clks(2);
      check_eq("irq_rie_idle", 8'(irq_n), 8'h01);
      send_frame(8'h3C, 1'b1);
      check_eq("irq_rie_set", 8'(irq_n), 8'h00);
      bus_read(1'b0, rd);
      check_eq("status_irq_rx", rd, 8'h83);
      bus_read(1'b1, rd);
      check_eq("data_rx_3c", rd, 8'h3C);
      check_eq("irq_still_low", 8'(irq_n), 8'h00);
      @(negedge clk);
      check_eq("irq_released", 8'(irq_n), 8'h01);

      // transmit interrupt with TDRE=1
      bus_write(1'b0, 8'h20);
      check_eq("irq_tie_lag", 8'(irq_n), 8'h01);
      @(negedge clk);
      check_eq("irq_tie_set", 8'(irq_n), 8'h00);
      bus_read(1'b0, rd);
      check_eq("status_irq_tx", rd, 8'h82);
      bus_write(1'b0, 8'h00);
      wait_clks(2);
      check_eq("irq_cleared", 8'(irq_n), 8'h01);

      // two bytes without a read: second overwrites
`ifdef ACIA_OVERRUN_EN
      exp_ovr_status = 8'h23;
`else
      exp_ovr_status = 8'h03;
`endif
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      bus_read(1'b0, rd);
      check_eq("status_overrun", rd, exp_ovr_status);
      bus_read(1'b1, rd);
      check_eq("data_overwrite", rd, 8'h22);
      bus_read(1'b0, rd);
      check_eq("status_overrun_clr", rd, 8'h02);

      // short low glitch is rejected as a false start
      @(negedge clk);
      rx = 1'b0;
      wait_clks(20);
      rx = 1'b1;
      wait_clks(700);
      bus_read(1'b0, rd);
      check_eq("status_glitch", rd, 8'h02);

      // framing error drops the byte, then the receiver re-arms
      send_frame(8'h5A, 1'b0);
      bus_read(1'b0, rd);
      check_eq("status_framing", rd, 8'h02);
      bus_read(1'b1, rd);
      check_eq("data_framing", rd, 8'h22);
      send_frame(8'h81, 1'b1);
      bus_read(1'b0, rd);
      check_eq("status_rearm", rd, 8'h03);
      bus_read(1'b1, rd);
      check_eq("data_rearm", rd, 8'h81);

      // master reset mid transmission, with a byte pending
      send_frame(8'h44, 1'b1);
      bus_write(1'b1, 8'h00);
      wait_clks(150);
      check_eq("tx_before_mreset", 8'(tx), 8'h00);
      bus_write(1'b0, 8'h03);
      check_eq("tx_after_mreset", 8'(tx), 8'h01);
      bus_read(1'b0, rd);
      check_eq("status_after_mreset", rd, 8'h02);
      wait_clks(100);
      check_eq("tx_stays_idle", 8'(tx), 8'h01);
      bus_write(1'b0, 8'h00);

      // asynchronous reset mid frame releases tx at once
      bus_write(1'b1, 8'h00);
      wait_clks(100);
      check_eq("tx_before_areset", 8'(tx), 8'h00);
      reset_n = 1'b0;
      #1;
      check_eq("tx_async_reset", 8'(tx), 8'h01);
      wait_clks(2);
      reset_n = 1'b1;
      wait_clks(2);
      bus_read(1'b0, rd);
      check_eq("status_after_areset", rd, 8'h02);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
